// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus a small MMIO bank.
// Loads are answered in the request cycle; stores commit on the next edge.
module dmem_responder #(
  parameter int          N           = 32,
  parameter int          DEPTH_WORDS = 256,
  parameter logic [N-1:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [N-1:0] address,
  input  logic [N-1:0] wdata,
  output logic [N-1:0] mem_out,
  output logic [N-1:0] gpio_out,
  output logic         fault
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [N-1:0] RAM_BYTES = N'(DEPTH_WORDS * 4);
  localparam logic [N-1:0] OFF_GPIO  = N'(32'h00);
  localparam logic [N-1:0] OFF_CYC   = N'(32'h04);
  localparam logic [N-1:0] OFF_SC    = N'(32'h08);
  localparam logic [N-1:0] OFF_STAT  = N'(32'h0C);
  localparam logic [N-1:0] OFF_FADDR = N'(32'h10);

  logic [N-1:0] ram_q [DEPTH_WORDS];
  logic [N-1:0] gpio_q, gpio_d;
  logic [N-1:0] cycle_q;
  logic [N-1:0] store_q, store_d;
  logic [2:0]   status_q, status_d;
  logic [N-1:0] faddr_q, faddr_d;
  logic         fault_q;

  logic [N-1:0]  off;
  logic [AW-1:0] idx;
  logic          req, misal, ok;
  logic          hit_ram, hit_mmio, unmapped;
  logic          sel_gpio, sel_cyc, sel_sc, sel_stat, sel_fa;
  logic          ro_store;
  logic          wr_ram, wr_gpio, wr_stat;
  logic [2:0]    set_bits, clr_bits;
  logic [N-1:0]  rdata;

  // address decode and fault classification of the current request
  always_comb begin
    off      = address - MMIO_BASE;
    idx      = address[AW+1:2];
    req      = mem_read | mem_write;
    misal    = req && (address[1:0] != 2'b00);
    ok       = ~misal;
    hit_ram  = address < RAM_BYTES;
    hit_mmio = (address >= MMIO_BASE) && (off <= OFF_FADDR);
    sel_gpio = hit_mmio && (off == OFF_GPIO);
    sel_cyc  = hit_mmio && (off == OFF_CYC);
    sel_sc   = hit_mmio && (off == OFF_SC);
    sel_stat = hit_mmio && (off == OFF_STAT);
    sel_fa   = hit_mmio && (off == OFF_FADDR);
    unmapped = req && ok && !hit_ram
             && !(sel_gpio | sel_cyc | sel_sc | sel_stat | sel_fa);
    ro_store = mem_write && ok && (sel_cyc | sel_sc | sel_fa);
    wr_ram   = mem_write && ok && hit_ram;
    wr_gpio  = mem_write && ok && sel_gpio;
    wr_stat  = mem_write && ok && sel_stat;
    set_bits = {ro_store, unmapped, misal};
    clr_bits = wr_stat ? wdata[2:0] : 3'b000;
  end

  // load data mux; old contents are returned even when a store hits
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      hit_ram:  rdata = ram_q[idx];
      sel_gpio: rdata = gpio_q;
      sel_cyc:  rdata = cycle_q;
      sel_sc:   rdata = store_q;
      sel_stat: rdata = {{(N-3){1'b0}}, status_q};
      sel_fa:   rdata = faddr_q;
      default:  rdata = '0;
    endcase
    mem_out = (mem_read && ok) ? rdata : '0;
  end

  // next-state for the MMIO registers; a fault set beats a W1C clear
  always_comb begin
    gpio_d   = wr_gpio ? wdata : gpio_q;
    store_d  = (wr_ram | wr_gpio | wr_stat) ? store_q + 1'b1 : store_q;
    status_d = (status_q & ~clr_bits) | set_bits;
    faddr_d  = (|set_bits) ? address : faddr_q;
  end

  // MMIO register bank and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_q   <= '0;
      cycle_q  <= '0;
      store_q  <= '0;
      status_q <= '0;
      faddr_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      gpio_q   <= gpio_d;
      cycle_q  <= cycle_q + 1'b1;
      store_q  <= store_d;
      status_q <= status_d;
      faddr_q  <= faddr_d;
      fault_q  <= |status_d;
    end
  end

  // RAM array: not cleared by reset, but a store under reset is dropped
  always_ff @(posedge clk) begin
    if (!reset && wr_ram) ram_q[idx] <= wdata;
  end

  assign gpio_out = gpio_q;
  assign fault    = fault_q;

endmodule
